// File: rtl/mine_pkg.sv
// Shared types and helpers for the mine placement block.
package mine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GEN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mine_lfsr.sv
// Seedable Galois LFSR; a zero seed is replaced by 1 so the register never locks up.
module mine_lfsr #(
  parameter int unsigned          LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]    LFSR_TAPS = LFSR_W'(mine_pkg::DEF_LFSR_TAPS)
) (
  input  logic              in_clka,
  input  logic              in_rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] out_state
);

  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge in_clka) begin
    if (!in_rst_n) begin
      lfsr_q <= LFSR_W'(1);
    end else if (load) begin
      lfsr_q <= (seed == '0) ? LFSR_W'(1) : seed;
    end else if (step) begin
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  assign out_state = lfsr_q;

endmodule

// File: rtl/mine_placer.sv
// Places a clamped number of distinct mines on the board by rejection-sampling LFSR output.
module mine_placer
  import mine_pkg::*;
#(
  parameter int unsigned        ROWS      = 5,
  parameter int unsigned        COLS      = 5,
  parameter int unsigned        LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS = LFSR_W'(DEF_LFSR_TAPS),
  localparam int unsigned       CELLS     = ROWS * COLS,
  localparam int unsigned       IDX_W     = clog2(CELLS),
  localparam int unsigned       CNT_W     = clog2(CELLS + 1)
) (
  input  logic              in_clka,
  input  logic              in_rst_n,
  input  logic              in_start,
  input  logic [LFSR_W-1:0] in_seed,
  input  logic [CNT_W-1:0]  in_mines_num,
  input  logic              in_safe_en,
  input  logic [IDX_W-1:0]  in_safe_idx,
  output logic              out_busy,
  output logic              out_place_done,
  output logic [CNT_W-1:0]  out_mine_count,
  output logic [CELLS-1:0]  out_mines
);

  state_e            state_q;
  logic [LFSR_W-1:0] seed_q;
  logic              safe_en_q;
  logic [IDX_W-1:0]  safe_idx_q;
  logic [CNT_W-1:0]  target_q;
  logic [LFSR_W-1:0] lfsr;

  logic [CNT_W-1:0]  cap;
  logic [CNT_W-1:0]  target_d;
  logic [CNT_W-1:0]  count_d;
  logic [IDX_W-1:0]  cand;
  logic              in_range;
  logic              accept;
  logic              unused_lfsr;

  mine_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_lfsr (
    .in_clka   (in_clka),
    .in_rst_n  (in_rst_n),
    .load      (state_q == LOAD),
    .seed      (seed_q),
    .step      (state_q == GEN),
    .out_state (lfsr)
  );

  // Only the low IDX_W bits form a candidate; the rest just feed the sequence.
  assign unused_lfsr = ^lfsr;

  always_comb begin
    cap      = CNT_W'(CELLS) - CNT_W'(in_safe_en);
    target_d = (in_mines_num < cap) ? in_mines_num : cap;
    cand     = lfsr[IDX_W-1:0];
    in_range = CNT_W'(cand) < CNT_W'(CELLS);
    accept   = in_range && !(safe_en_q && (cand == safe_idx_q)) && !out_mines[cand];
    count_d  = out_mine_count + CNT_W'(1);
  end

  always_ff @(posedge in_clka) begin
    if (!in_rst_n) begin
      state_q        <= IDLE;
      seed_q         <= '0;
      safe_en_q      <= 1'b0;
      safe_idx_q     <= '0;
      target_q       <= '0;
      out_mines      <= '0;
      out_mine_count <= '0;
      out_busy       <= 1'b0;
      out_place_done <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (in_start) begin
            state_q        <= LOAD;
            seed_q         <= in_seed;
            safe_en_q      <= in_safe_en;
            safe_idx_q     <= in_safe_idx;
            target_q       <= target_d;
            out_mines      <= '0;
            out_mine_count <= '0;
            out_busy       <= 1'b1;
            out_place_done <= 1'b0;
          end
        end
        LOAD: begin
          if (target_q == '0) begin
            state_q        <= DONE;
            out_busy       <= 1'b0;
            out_place_done <= 1'b1;
          end else begin
            state_q <= GEN;
          end
        end
        GEN: begin
          if (accept) begin
            out_mines[cand] <= 1'b1;
            out_mine_count  <= count_d;
            if (count_d == target_q) begin
              state_q        <= DONE;
              out_busy       <= 1'b0;
              out_place_done <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Randomised bench for mine_placer against a cycle-level behavioural placement model.
module tb_mine_placer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] seed;
  logic [4:0]  mines_num;
  logic        safe_en;
  logic [4:0]  safe_idx;
  logic        busy;
  logic        done;
  logic [4:0]  mine_count;
  logic [24:0] mines;

  int n_pass  = 0;
  int n_total = 0;

  logic [24:0] exp_q[$];
  logic [24:0] final_mines;

  always #5 clk = ~clk;

  mine_placer dut (
    .in_clka        (clk),
    .in_rst_n       (rst_n),
    .in_start       (start),
    .in_seed        (seed),
    .in_mines_num   (mines_num),
    .in_safe_en     (safe_en),
    .in_safe_idx    (safe_idx),
    .out_busy       (busy),
    .out_place_done (done),
    .out_mine_count (mine_count),
    .out_mines      (mines)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int next_lfsr(input int x);
    return (x / 2) ^ (((x % 2) == 1) ? 32'hB400 : 0);
  endfunction

  function automatic int target_of(input int num, input bit se);
    int cap;
    cap = 25 - int'(se);
    return (num < cap) ? num : cap;
  endfunction

  // Expected bitmap after every GEN cycle, from the placement rules directly.
  task automatic build_model(input int sd, input int num, input bit se, input int si);
    bit [24:0] bm;
    int cnt, l, c, guard, tgt;
    exp_q.delete();
    bm = '0; cnt = 0; guard = 0;
    tgt = target_of(num, se);
    l = (sd == 0) ? 1 : sd;
    while (cnt < tgt && guard < 70000) begin
      c = l % 32;
      if (c < 25 && !(se && c == si) && !bm[c]) begin
        bm[c] = 1'b1;
        cnt++;
      end
      exp_q.push_back(bm);
      l = next_lfsr(l);
      guard++;
    end
  endtask

  task automatic run(input logic [15:0] sd, input int num, input bit se, input int si,
                     input int intr_at, input string tag);
    int tgt, n;
    build_model(int'(sd), num, se, si);
    tgt = target_of(num, se);
    n = exp_q.size();
    @(negedge clk);
    start = 1'b1; seed = sd; mines_num = 5'(num); safe_en = se; safe_idx = 5'(si);
    @(posedge clk); #1;
    check($sformatf("%s load busy", tag), 64'(busy), 64'(1));
    check($sformatf("%s load cleared", tag), 64'({done, mine_count, mines}), 64'(0));
    @(negedge clk);
    start = 1'b0; seed = ~sd; mines_num = 5'($urandom); safe_en = ~se; safe_idx = 5'($urandom);
    @(posedge clk); #1;
    if (tgt == 0) begin
      check($sformatf("%s zero done", tag), 64'({busy, done, mine_count, mines}), 64'({2'b01, 30'd0}));
    end else begin
      check($sformatf("%s gen entry", tag), 64'({busy, done, mine_count, mines}), 64'({2'b10, 30'd0}));
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        start = (i == intr_at);
        if (i == intr_at) seed = sd ^ 16'h5A5A;
        @(posedge clk); #1;
        check($sformatf("%s cyc%0d mines", tag, i), 64'(mines), 64'(exp_q[i]));
        check($sformatf("%s cyc%0d cnt/done", tag, i),
              64'({busy, done, mine_count}),
              64'({(i != n - 1), (i == n - 1), 5'($countones(exp_q[i]))}));
      end
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk); #1;
    check($sformatf("%s hold", tag), 64'({busy, done, mine_count}), 64'({2'b01, 5'(tgt)}));
    final_mines = mines;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; seed = '0; mines_num = '0; safe_en = 1'b0; safe_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 64'({busy, done, mine_count, mines}), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    run(16'h1234, 0, 1'b0, 0, -1, "zero");
    run(16'hACE1, 25, 1'b0, 0, -1, "full");
    check("full bitmap", 64'(final_mines), 64'(25'h1FFFFFF));
    run(16'h3C5A, 31, 1'b1, 12, -1, "clamp");
    check("clamp bitmap", 64'(final_mines), 64'(25'h1FFEFFF));
    run(16'h0000, 5, 1'b0, 0, -1, "seed0");
    run(16'h0001, 5, 1'b0, 0, -1, "seed1");
    run(16'hBEEF, 8, 1'b1, 3, 2, "startgen");

    // Reset on the third GEN cycle of a 10-mine run.
    build_model(16'h7777, 10, 1'b0, 0);
    @(negedge clk);
    start = 1'b1; seed = 16'h7777; mines_num = 5'd10; safe_en = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset mines", 64'(mines), 64'(exp_q[1]));
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid-gen reset", 64'({busy, done, mine_count, mines}), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    run(16'h00FF, 10, 1'b0, 0, -1, "after-reset");
    check("after-reset popcount", 64'($countones(final_mines)), 64'(10));

    for (int k = 0; k < 8; k++) begin
      run(16'($urandom), int'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 24)),
          int'($urandom_range(0, 3)) - 1, $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
